// File: rtl/zpu_disk_pkg.sv
// Shared constants for the ZPU <-> hps_io disk bridge.
//   - request FSM state encodings
//   - bit positions inside the ZPU OUT2 control word
//   - field positions inside the ZPU IN2 status word
package zpu_disk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  localparam int O2_LBA_SEL  = 0;
  localparam int O2_BLK_RD   = 1;
  localparam int O2_BLK_WR   = 2;
  localparam int O2_DRV_LSB  = 3;

  localparam int I2_DONE     = 0;
  localparam int I2_TOGGLE   = 1;
  localparam int I2_FILENO   = 2;
  localparam int I2_TYPE     = 5;
  localparam int I2_RO       = 7;
  localparam int I2_ERR      = 8;
  localparam int I2_BUSY     = 9;
  localparam int I2_PEND     = 10;

endpackage

// File: rtl/sd_sector_buf.sv
// True dual-port byte RAM holding one sector.
//   Port A (ZPU side):    addr_a, we_a, din_a -> dout_a (1-cycle read)
//   Port B (hps_io side): addr_b, we_b, din_b -> dout_b (1-cycle read)
// Same-address collisions between the ports give undefined data.
module sd_sector_buf #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic          we_a,
  input  logic [7:0]    din_a,
  output logic [7:0]    dout_a,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  input  logic [7:0]    din_b,
  output logic [7:0]    dout_b
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/zpu_disk_bridge.sv
// Bridge between the ZPU firmware register interface and hps_io SD
// block-device signals for NUM_DRV virtual drives.
//   clk_sys/reset            : clock, synchronous active-high reset
//   zpu_out2/out3, strobes   : firmware control word, LBA/data, io/data strobes
//   zpu_in2/zpu_in3          : status word, filesize or buffer byte
//   sd_*                     : hps_io block request and sector buffer port
//   img_*                    : mount events, queued per drive
module zpu_disk_bridge
  import zpu_disk_pkg::*;
#(
  parameter int                 NUM_DRV     = 3,
  parameter int                 BUF_AW      = 9,
  parameter logic [NUM_DRV-1:0] RO_MASK     = NUM_DRV'(3'b100),
  parameter int                 TIMEOUT_CYC = 0
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [31:0]        zpu_out2,
  input  logic [31:0]        zpu_out3,
  input  logic               zpu_io_wr,
  input  logic               zpu_data_wr,
  input  logic               zpu_data_rd,
  output logic [15:0]        zpu_in2,
  output logic [31:0]        zpu_in3,
  output logic [31:0]        sd_lba,
  output logic [NUM_DRV-1:0] sd_rd,
  output logic [NUM_DRV-1:0] sd_wr,
  input  logic               sd_ack,
  input  logic [BUF_AW-1:0]  sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  input  logic [NUM_DRV-1:0] img_mounted,
  input  logic               img_readonly,
  input  logic [63:0]        img_size,
  input  logic [1:0]         img_type
);

  logic unused_ok;
  assign unused_ok = ^{zpu_out2[31:6], img_size[63:32]};

  // Strobe / edge trackers follow their inputs even during reset so no
  // spurious edge appears when reset releases.
  logic [1:0] wr_sync_q;
  logic       wr_dly_q, rd_q, ack_q;
  logic [1:0] blk_q;

  always_ff @(posedge clk_sys) begin
    wr_sync_q <= {wr_sync_q[0], zpu_data_wr};
    wr_dly_q  <= wr_sync_q[1];
    rd_q      <= zpu_data_rd;
    ack_q     <= sd_ack;
    blk_q     <= {zpu_out2[O2_BLK_WR], zpu_out2[O2_BLK_RD]};
  end

  logic lba_sel, wr_rise, rd_fall, byte_we;
  assign lba_sel = zpu_out2[O2_LBA_SEL];
  assign wr_rise = wr_sync_q[1] & ~wr_dly_q;
  assign rd_fall = rd_q & ~zpu_data_rd;
  assign byte_we = wr_rise & ~lba_sel;

  // Buffer pointer: a byte write bumps it one cycle later (inc_q) so the
  // write lands at the old address.
  logic [BUF_AW-1:0] ptr_q;
  logic              inc_q;
  logic [31:0]       lba_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ptr_q <= '0;
      inc_q <= 1'b0;
      lba_q <= '0;
    end else begin
      inc_q <= byte_we;
      if (wr_rise && lba_sel) lba_q <= zpu_out3;
      if (zpu_io_wr)              ptr_q <= '0;
      else if (inc_q || rd_fall)  ptr_q <= ptr_q + BUF_AW'(1);
    end
  end
  assign sd_lba = lba_q;

  logic [7:0] buf_dout_a;

  sd_sector_buf #(.AW(BUF_AW)) u_buf (
    .clk    (clk_sys),
    .addr_a (ptr_q),
    .we_a   (byte_we),
    .din_a  (zpu_out3[7:0]),
    .dout_a (buf_dout_a),
    .addr_b (sd_buff_addr),
    .we_b   (sd_buff_wr),
    .din_b  (sd_buff_dout),
    .dout_b (sd_buff_din)
  );

  // Request FSM
  logic [1:0]         state_q, state_d;
  logic [NUM_DRV-1:0] rd_q_o, rd_d, wr_q_o, wr_d;
  logic               done_q, done_d, err_q, err_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [2:0]         drv;
  logic               drv_ok, rd_edge, wr_edge;
  logic [NUM_DRV-1:0] drv_oh;

  assign drv     = zpu_out2[O2_DRV_LSB +: 3];
  assign drv_ok  = {1'b0, drv} < 4'(NUM_DRV);
  assign drv_oh  = NUM_DRV'(1) << drv;
  assign rd_edge = zpu_out2[O2_BLK_RD] & ~blk_q[0];
  assign wr_edge = zpu_out2[O2_BLK_WR] & ~blk_q[1];

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q_o;
    wr_d    = wr_q_o;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (rd_edge || wr_edge) begin
        if (drv_ok) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_REQ;
          if (rd_edge) rd_d = drv_oh;   // read wins a tie
          else         wr_d = drv_oh;
        end else begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          rd_d    = '0;
          wr_d    = '0;
          state_d = ST_XFER;
        end else if (TIMEOUT_CYC != 0 && cnt_q == 32'(TIMEOUT_CYC - 1)) begin
          rd_d    = '0;
          wr_d    = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_XFER: if (ack_q && !sd_ack) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rd_q_o  <= '0;
      wr_q_o  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q_o  <= rd_d;
      wr_q_o  <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign sd_rd = rd_q_o;
  assign sd_wr = wr_q_o;

  // Mount queue: per-drive slots, lowest pending drive presented first.
  logic [NUM_DRV-1:0] pend_q, pend_d, sel_oh;
  logic [1:0]         slot_type_q [NUM_DRV];
  logic               slot_ro_q   [NUM_DRV];
  logic [31:0]        slot_size_q [NUM_DRV];
  logic               outst_q, toggle_q, mro_q, present;
  logic [2:0]         fileno_q, sel_idx;
  logic [1:0]         mtype_q, sel_type;
  logic [31:0]        fsize_q, sel_size;
  logic               sel_ro;

  always_comb begin
    sel_idx  = '0;
    sel_type = '0;
    sel_ro   = 1'b0;
    sel_size = '0;
    for (int i = NUM_DRV - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_idx  = 3'(i);
        sel_type = slot_type_q[i];
        sel_ro   = slot_ro_q[i];
        sel_size = slot_size_q[i];
      end
    end
  end

  // Presentation waits out the io_wr cycle that acknowledged the previous event.
  assign present = ~outst_q & ~zpu_io_wr & (|pend_q);
  assign sel_oh  = pend_q & (~pend_q + NUM_DRV'(1));
  assign pend_d  = (pend_q & ~(present ? sel_oh : '0)) | img_mounted;

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NUM_DRV; i++) begin
      if (img_mounted[i]) begin
        slot_type_q[i] <= img_type;
        slot_ro_q[i]   <= img_readonly | RO_MASK[i];
        slot_size_q[i] <= img_size[31:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_q   <= '0;
      outst_q  <= 1'b0;
      toggle_q <= 1'b0;
      fileno_q <= '0;
      mtype_q  <= '0;
      mro_q    <= 1'b0;
      fsize_q  <= '0;
    end else begin
      pend_q <= pend_d;
      if (present) begin
        fileno_q <= sel_idx;
        mtype_q  <= sel_type;
        mro_q    <= sel_ro;
        fsize_q  <= sel_size;
        toggle_q <= ~toggle_q;
        outst_q  <= 1'b1;
      end else if (zpu_io_wr) begin
        outst_q <= 1'b0;
      end
    end
  end

  always_comb begin
    zpu_in2                        = '0;
    zpu_in2[I2_DONE]               = done_q;
    zpu_in2[I2_TOGGLE]             = toggle_q;
    zpu_in2[I2_FILENO +: 3]        = fileno_q;
    zpu_in2[I2_TYPE +: 2]          = mtype_q;
    zpu_in2[I2_RO]                 = mro_q;
    zpu_in2[I2_ERR]                = err_q;
    zpu_in2[I2_BUSY]               = (state_q != ST_IDLE);
    zpu_in2[I2_PEND]               = |pend_q;
  end

  assign zpu_in3 = lba_sel ? fsize_q : {24'b0, buf_dout_a};

endmodule

// File: tb/tb_zpu_disk_bridge.sv
module tb_zpu_disk_bridge;
  localparam int ND = 3, AW = 9, TO = 100, BSZ = 512;
  localparam logic [2:0] ROM = 3'b100;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        reset = 1;
  logic [31:0] zpu_out2 = 0, zpu_out3 = 0;
  logic        zpu_io_wr = 0, zpu_data_wr = 0, zpu_data_rd = 0;
  logic [15:0] zpu_in2;
  logic [31:0] zpu_in3, sd_lba;
  logic [ND-1:0] sd_rd, sd_wr;
  logic        sd_ack = 0;
  logic [AW-1:0] sd_buff_addr = 0;
  logic [7:0]  sd_buff_dout = 0, sd_buff_din;
  logic        sd_buff_wr = 0;
  logic [ND-1:0] img_mounted = 0;
  logic        img_readonly = 0;
  logic [63:0] img_size = 0;
  logic [1:0]  img_type = 0;

  zpu_disk_bridge #(.NUM_DRV(ND), .BUF_AW(AW), .RO_MASK(ROM), .TIMEOUT_CYC(TO)) dut (
    .clk_sys(clk), .reset(reset), .zpu_out2(zpu_out2), .zpu_out3(zpu_out3),
    .zpu_io_wr(zpu_io_wr), .zpu_data_wr(zpu_data_wr), .zpu_data_rd(zpu_data_rd),
    .zpu_in2(zpu_in2), .zpu_in3(zpu_in3), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .img_type(img_type));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte array, pointer, LBA, mount slots and pending set.
  logic [7:0]  mem_m [BSZ];
  int          ptr_m = 0;
  logic [31:0] lba_m = 0;
  bit          pend_m [ND];
  logic [1:0]  type_m [ND];
  bit          ro_m   [ND];
  logic [31:0] size_m [ND];
  bit          out_m = 0, tog_m = 0;
  int          fno_e = 0;
  logic [1:0]  type_e = 0;
  bit          ro_e = 0;
  logic [31:0] size_e = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < ND; i++) if (pend_m[i]) return 1;
    return 0;
  endfunction

  task automatic m_present();
    for (int i = 0; i < ND; i++) begin
      if (pend_m[i]) begin
        fno_e = i; type_e = type_m[i]; ro_e = ro_m[i]; size_e = size_m[i];
        pend_m[i] = 0; tog_m = ~tog_m; out_m = 1;
        return;
      end
    end
  endtask

  task automatic hps_wr(input int a, input logic [7:0] d);
    sd_buff_addr = AW'(a); sd_buff_dout = d; sd_buff_wr = 1;
    tick();
    sd_buff_wr = 0;
    mem_m[a] = d;
  endtask

  task automatic hps_rd_chk(input int a);
    sd_buff_addr = AW'(a);
    tick();
    chk("hps_rd", sd_buff_din, mem_m[a]);
  endtask

  task automatic zwr(input logic [31:0] o2, input logic [31:0] o3);
    zpu_out2 = o2; zpu_out3 = o3; zpu_data_wr = 1;
    tick();
    zpu_data_wr = 0;
    repeat (4) tick();
    if (o2[0]) lba_m = o3;
    else begin
      mem_m[ptr_m] = o3[7:0];
      ptr_m = (ptr_m + 1) % BSZ;
    end
    zpu_out2 = 0;
  endtask

  task automatic zrd();
    zpu_data_rd = 1; tick();
    zpu_data_rd = 0; tick(); tick();
    ptr_m = (ptr_m + 1) % BSZ;
  endtask

  task automatic zio();
    zpu_io_wr = 1; tick();
    zpu_io_wr = 0; tick(); tick();
    ptr_m = 0;
    out_m = 0;
    if (any_pend()) m_present();
  endtask

  task automatic chk_in3(input string tag);
    chk(tag, zpu_in3, {24'b0, mem_m[ptr_m]});
  endtask

  task automatic mnt_pulse(input logic [2:0] mask);
    logic [1:0]  t;
    logic [31:0] s;
    bit          r;
    t = 2'($urandom_range(0, 3)); s = $urandom; r = 1'($urandom_range(0, 1));
    img_mounted = mask; img_type = t; img_size = {32'hDEAD_0000, s}; img_readonly = r;
    tick();
    img_mounted = 0;
    for (int i = 0; i < ND; i++) begin
      if (mask[i]) begin
        pend_m[i] = 1; type_m[i] = t; size_m[i] = s; ro_m[i] = r | ROM[i];
      end
    end
    tick();
    if (!out_m && any_pend()) m_present();
  endtask

  task automatic chk_mnt();
    chk("mnt_toggle", zpu_in2[1], tog_m);
    chk("mnt_fileno", zpu_in2[4:2], fno_e);
    chk("mnt_type",   zpu_in2[6:5], type_e);
    chk("mnt_ro",     zpu_in2[7], ro_e);
    chk("mnt_pend",   zpu_in2[10], any_pend());
    zpu_out2 = 1; #1;
    chk("mnt_fsize", zpu_in3, size_e);
    zpu_out2 = 0; #1;
  endtask

  task automatic req(input int drv, input bit is_wr, input int dly);
    zpu_out2 = (drv << 3) | (is_wr ? 4 : 2);
    tick();
    if (drv < ND) begin
      chk("req_bits", is_wr ? sd_wr : sd_rd, 1 << drv);
      chk("req_other", is_wr ? sd_rd : sd_wr, 0);
      chk("req_busy", zpu_in2[9], 1);
      repeat (dly) tick();
      chk("req_hold", is_wr ? sd_wr : sd_rd, 1 << drv);
      sd_ack = 1; tick();
      chk("ack_clr", sd_rd | sd_wr, 0);
      sd_ack = 0;
      chk("xfer_done0", zpu_in2[0], 0);
      tick();
      chk("xfer_done", {zpu_in2[9:8], zpu_in2[0]}, 3'b001);
    end else begin
      chk("bad_drv_req", sd_rd | sd_wr, 0);
      chk("bad_drv_st", {zpu_in2[9:8], zpu_in2[0]}, 3'b011);
    end
    chk("lba", sd_lba, lba_m);
    zpu_out2 = 0; tick();
  endtask

  initial begin
    int n;
    for (int i = 0; i < ND; i++) pend_m[i] = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_in2", zpu_in2, 0);

    for (int a = 0; a < BSZ; a++) hps_wr(a, 8'($urandom));

    // LBA and a read request
    zwr(1, 32'h1234_5678);
    chk("lba_set", sd_lba, 32'h1234_5678);
    req(1, 0, 3);

    // Buffer round trip
    hps_wr(0, 8'hA5); hps_wr(1, 8'h5A);
    zio();
    chk("rt_byte0", zpu_in3, 32'hA5);
    zrd();
    chk("rt_byte1", zpu_in3, 32'h5A);

    // Pointer wrap over a full sector
    zio();
    for (int i = 0; i < BSZ; i++) zwr(0, $urandom);
    chk_in3("wrap_ptr0");
    zrd(); chk_in3("wrap_ptr1");
    hps_rd_chk(0); hps_rd_chk(BSZ - 1);

    // Random buffer traffic
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: begin zwr(0, $urandom); chk_in3("rnd_zwr"); end
        1: begin zrd(); chk_in3("rnd_zrd"); end
        2: begin zio(); chk_in3("rnd_zio"); end
        default: begin
          hps_wr($urandom_range(0, BSZ - 1), 8'($urandom));
          hps_rd_chk($urandom_range(0, BSZ - 1));
        end
      endcase
    end

    // Simultaneous mounts on drives 0 and 2
    mnt_pulse(3'b101);
    chk("mnt_first_drv", zpu_in2[4:2], 0);
    chk("mnt_first_tog", zpu_in2[1], 1);
    chk_mnt();
    repeat (3) tick();
    chk("mnt_held", zpu_in2[4:2], 0);
    zio();
    chk("mnt_second_drv", zpu_in2[4:2], 2);
    chk("mnt_second_ro", zpu_in2[7], 1);
    while (out_m) begin chk_mnt(); zio(); end

    // Random mount bursts, second burst may overwrite pending slots
    for (int k = 0; k < 5; k++) begin
      mnt_pulse(3'($urandom_range(1, 7)));
      mnt_pulse(3'($urandom_range(1, 7)));
      while (out_m) begin chk_mnt(); zio(); end
    end

    // Random requests, including out-of-range drives
    for (int k = 0; k < 12; k++) begin
      zwr(1, $urandom);
      req($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 10));
    end
    req(0, 1, 1);
    req(5, 0, 0);

    // Timeout on a write that never gets an ack
    zpu_out2 = 4; tick();
    chk("to_req", sd_wr, 3'b001);
    n = 0;
    while (sd_wr[0] && n < 200) begin n++; tick(); end
    chk("to_cycles", n, TO);
    chk("to_status", {zpu_in2[9:8], zpu_in2[0]}, 3'b011);
    zpu_out2 = 0; tick();

    // Reset during REQ
    zpu_out2 = (2 << 3) | 2; tick();
    chk("mid_req", sd_rd, 3'b100);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_rd", sd_rd, 0);
    chk("mid_rst_st", {zpu_in2[9:8], zpu_in2[0]}, 3'b000);
    ptr_m = 0; lba_m = 0; tog_m = 0; out_m = 0;
    zpu_out2 = 0; tick();
    chk("mid_rst_lba", sd_lba, 0);
    req(0, 0, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
